ammeter_pwm_multi: RTL

//  Multi-channel ammeter needle driver; successor to the single-channel minute/second PWM drivers.

---
 rtl/ammeter_pkg.sv | 24 ++
 rtl/ammeter_pwm_multi_if.sv | 14 +
 rtl/ammeter_udiv.sv | 79 +++++++
 rtl/ammeter_pwm_multi.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ammeter_pkg.sv
// Shared types, constants and the ramp helper for the multi-channel ammeter PWM driver.
package ammeter_pkg;

   localparam int unsigned DEF_PERIOD = 100000;
   localparam int unsigned CAL_UNITY  = 128;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StDiv,
      StStore,
      StDone
   } fsm_t;

   // Move cur toward tgt by at most up_step when rising or dn_step when falling.
   function automatic int unsigned ramp_next(input int unsigned cur, input int unsigned tgt,
                                             input int unsigned up_step,
                                             input int unsigned dn_step);
      if (tgt > cur) return (tgt - cur > up_step) ? cur + up_step : tgt;
      if (cur > tgt) return (cur - tgt > dn_step) ? cur - dn_step : tgt;
      return cur;
   endfunction

endpackage

// File: rtl/ammeter_pwm_multi_if.sv
// Load/ready conversion handshake between the time-keeping logic and the ammeter driver.
interface ammeter_pwm_multi_if #(
   parameter int unsigned CH    = 3,
   parameter int unsigned IDX_W = 8
);
   logic                  load;
   logic                  ready;
   logic                  done;
   logic [CH*IDX_W-1:0]   time_data;
   logic [CH*IDX_W-1:0]   time_max;

   modport master (output load, time_data, time_max, input ready, done);
   modport slave  (input load, time_data, time_max, output ready, done);
endinterface

// File: rtl/ammeter_udiv.sv
// Sequential restoring divider, one quotient bit per cycle for PERIOD_W cycles.
module ammeter_udiv #(
   parameter int unsigned IDX_W    = 8,
   parameter int unsigned PERIOD_W = 17
) (
   input  logic                      clk,
   input  logic                      Rst_n,
   input  logic                      start,
   input  logic [IDX_W+PERIOD_W-1:0] num,
   input  logic [IDX_W-1:0]          den,
   output logic [PERIOD_W-1:0]       q,
   output logic                      valid
);
   localparam int unsigned CNT_W = $clog2(PERIOD_W);

   logic [IDX_W-1:0]    rem_q, rem_d, den_q, den_d;
   logic [PERIOD_W-1:0] lo_q, lo_d, q_q, q_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d, valid_q, valid_d;
   logic [IDX_W:0]      trial;

   // The quotient fits in PERIOD_W bits, so the upper num bits are already below den.
   always_comb begin
      rem_d   = rem_q;
      den_d   = den_q;
      lo_d    = lo_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      trial   = {rem_q, lo_q[PERIOD_W-1]};
      if (start) begin
         rem_d  = num[IDX_W+PERIOD_W-1:PERIOD_W];
         lo_d   = num[PERIOD_W-1:0];
         den_d  = den;
         q_d    = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         lo_d = lo_q << 1;
         if (trial >= {1'b0, den_q}) begin
            rem_d = IDX_W'(trial - {1'b0, den_q});
            q_d   = {q_q[PERIOD_W-2:0], 1'b1};
         end else begin
            rem_d = trial[IDX_W-1:0];
            q_d   = {q_q[PERIOD_W-2:0], 1'b0};
         end
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(PERIOD_W - 1)) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!Rst_n) begin
         rem_q   <= '0;
         den_q   <= '0;
         lo_q    <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         rem_q   <= rem_d;
         den_q   <= den_d;
         lo_q    <= lo_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign q     = q_q;
   assign valid = valid_q;

endmodule

// File: rtl/ammeter_pwm_multi.sv
// Multi-channel ammeter needle driver: index-to-duty conversion, slew-limited PWM.
// Optional per-channel calibration gain is enabled with AMMETER_CAL_EN.
module ammeter_pwm_multi
   import ammeter_pkg::*;
#(
   parameter int unsigned CH         = 3,
   parameter int unsigned IDX_W      = 8,
   parameter int unsigned PERIOD     = DEF_PERIOD,
   parameter int unsigned PERIOD_W   = 17,
   parameter int unsigned RAMP_STEP  = 200,
   parameter int unsigned WRAP_SHIFT = 3
) (
   input  logic                  clk,
   input  logic                  Rst_n,
   input  logic                  En,
   ammeter_pwm_multi_if.slave    bus,
`ifdef AMMETER_CAL_EN
   input  logic [CH*8-1:0]       cal_gain,
`endif
   output logic [CH-1:0]         at_target,
   output logic [CH-1:0]         pwm_o
);
   localparam int unsigned NUM_W   = IDX_W + PERIOD_W;
   localparam int unsigned CH_W    = (CH > 1) ? $clog2(CH) : 1;
   localparam int unsigned DC_W    = $clog2(PERIOD_W);
   localparam int unsigned DN_STEP = RAMP_STEP << WRAP_SHIFT;

   fsm_t                state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [DC_W-1:0]     dcnt_q, dcnt_d;
   logic [CH*IDX_W-1:0] data_q, data_d, max_q, max_d;
   logic [PERIOD_W-1:0] tgt_q [CH];
   logic [PERIOD_W-1:0] tgt_d [CH];
   logic [PERIOD_W-1:0] duty_q [CH];
   logic [PERIOD_W-1:0] duty_d [CH];
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                accept, div_start, div_valid, period_end, store_last;
   logic [IDX_W-1:0]    cur_idx, cur_max, clip_idx;
   logic [NUM_W-1:0]    num;
   logic [PERIOD_W-1:0] q, q_eff;

   assign bus.ready = (state_q == StIdle) && !done_q;
   assign bus.done  = done_q;
   assign accept    = bus.load && bus.ready;
   assign div_start = (state_q == StSetup);
   assign cur_idx   = data_q[32'(ch_q)*IDX_W +: IDX_W];
   assign cur_max   = max_q[32'(ch_q)*IDX_W +: IDX_W];
   assign clip_idx  = (cur_idx > cur_max) ? cur_max : cur_idx;
   assign num       = NUM_W'(clip_idx) * NUM_W'(PERIOD);
   // A zero full-scale still runs the divider so latency stays fixed; the result is discarded.
   assign q_eff     = (cur_max == '0) ? '0 : q;

   ammeter_udiv #(
      .IDX_W    (IDX_W),
      .PERIOD_W (PERIOD_W)
   ) u_div (
      .clk   (clk),
      .Rst_n (Rst_n),
      .start (div_start),
      .num   (num),
      .den   (cur_max),
      .q     (q),
      .valid (div_valid)
   );

`ifdef AMMETER_CAL_EN
   logic                store_ph_q, store_ph_d;
   logic [PERIOD_W-1:0] cal_q, cal_d, cal_sat;
   logic [PERIOD_W+7:0] cal_prod;

   assign cal_prod   = ((PERIOD_W+8)'(q_eff) * (PERIOD_W+8)'(cal_gain[32'(ch_q)*8 +: 8]))
                       >> $clog2(CAL_UNITY);
   assign cal_sat    = (cal_prod > (PERIOD_W+8)'(PERIOD)) ? PERIOD_W'(PERIOD)
                                                          : PERIOD_W'(cal_prod);
   assign store_last = store_ph_q;
`else
   assign store_last = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      dcnt_d  = dcnt_q;
      data_d  = data_q;
      max_d   = max_q;
      tgt_d   = tgt_q;
`ifdef AMMETER_CAL_EN
      store_ph_d = store_ph_q;
      cal_d      = cal_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               data_d  = bus.time_data;
               max_d   = bus.time_max;
               ch_d    = '0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            dcnt_d  = '0;
            state_d = StDiv;
         end
         StDiv: begin
            dcnt_d = dcnt_q + 1'b1;
            if (dcnt_q == DC_W'(PERIOD_W - 1)) state_d = StStore;
         end
         StStore: begin
`ifdef AMMETER_CAL_EN
            store_ph_d = !store_ph_q;
            if (!store_ph_q && div_valid) cal_d = cal_sat;
            if (store_ph_q) tgt_d[ch_q] = cal_q;
`else
            if (div_valid) tgt_d[ch_q] = q_eff;
`endif
            if (store_last) begin
               if (ch_q == CH_W'(CH - 1)) begin
                  state_d = StDone;
               end else begin
                  ch_d    = ch_q + 1'b1;
                  state_d = StSetup;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign done_d = (state_q == StDone);

   // Duties only move on the period boundary so every PWM period is whole.
   always_comb begin
      period_end = En && (cnt_q == PERIOD_W'(PERIOD - 1));
      cnt_d      = (!En || period_end) ? '0 : cnt_q + 1'b1;
      for (int c = 0; c < CH; c++) begin
         duty_d[c]    = period_end
                        ? PERIOD_W'(ramp_next(32'(duty_q[c]), 32'(tgt_q[c]), RAMP_STEP, DN_STEP))
                        : duty_q[c];
         pwm_o[c]     = En && (cnt_q < duty_q[c]);
         at_target[c] = (duty_q[c] == tgt_q[c]);
      end
   end

   always_ff @(posedge clk) begin
      if (!Rst_n) begin
         state_q <= StIdle;
         ch_q    <= '0;
         dcnt_q  <= '0;
         data_q  <= '0;
         max_q   <= '0;
         tgt_q   <= '{default: '0};
         duty_q  <= '{default: '0};
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         dcnt_q  <= dcnt_d;
         data_q  <= data_d;
         max_q   <= max_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

`ifdef AMMETER_CAL_EN
   always_ff @(posedge clk) begin
      if (!Rst_n) begin
         store_ph_q <= 1'b0;
         cal_q      <= '0;
      end else begin
         store_ph_q <= store_ph_d;
         cal_q      <= cal_d;
      end
   end
`endif

endmodule
